// File: rtl/jksc_pkg.sv
// Shared mode and FSM encodings for the JK sequencer controller.
package jksc_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DN   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } jksc_state_e;

  function automatic logic mode_is_count(logic [1:0] m);
    return (m == MODE_UP) || (m == MODE_DN);
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset to 0.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      case ({j, k})
        2'b00:   q_q <= q_q;
        2'b01:   q_q <= 1'b0;
        2'b10:   q_q <= 1'b1;
        default: q_q <= ~q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Modulo-MOD up/down counter sequenced onto a bank of JK flip-flops.
// Define JKSC_SAT_EN to saturate at the limits instead of wrapping.
module jk_seq_ctrl
  import jksc_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] nxt;
  logic             at_max;
  logic             at_zero;
  logic             load_over;
  logic             tc_d;
  logic             tc_q;
  jksc_state_e      state_q;

  assign at_max    = (q == MaxVal);
  assign at_zero   = (q == '0);
  // Widen before comparing so MOD == 2**WIDTH never clamps.
  assign load_over = (32'(load_val) >= MOD);

  always_comb begin
    nxt  = q;
    tc_d = 1'b0;
    case (mode)
      MODE_UP: begin
        if (at_max) begin
          tc_d = 1'b1;
`ifdef JKSC_SAT_EN
          nxt  = q;
`else
          nxt  = '0;
`endif
        end else begin
          nxt = q + WIDTH'(1);
        end
      end
      MODE_DN: begin
        if (at_zero) begin
          tc_d = 1'b1;
`ifdef JKSC_SAT_EN
          nxt  = q;
`else
          nxt  = MaxVal;
`endif
        end else begin
          nxt = q - WIDTH'(1);
        end
      end
      MODE_LOAD: begin
        nxt = load_over ? MaxVal : load_val;
      end
      default: begin
        nxt = q;
      end
    endcase
  end

  // Unchanged bits resolve their don't-cares to 0, so J=K=1 never appears.
  assign j_vec = ~q & nxt;
  assign k_vec = q & ~nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tc_q    <= 1'b0;
    end else begin
      state_q <= mode_is_count(mode) ? ST_RUN : ST_IDLE;
      tc_q    <= tc_d;
    end
  end

  assign tc   = tc_q;
  assign busy = (state_q == ST_RUN);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bank
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_vec[i]),
      .k   (k_vec[i]),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Scoreboard bench for jk_seq_ctrl (WIDTH=4, MOD=10).
module tb_jk_seq_ctrl;

  localparam int W = 4;
  localparam int M = 10;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] UP   = 2'b01;
  localparam logic [1:0] DN   = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

  typedef struct packed {
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic [W-1:0] j_vec;
  logic [W-1:0] k_vec;
  logic         tc;
  logic         busy;

  int   checks = 0;
  int   failures = 0;
  int   mq = 0;
  exp_t sb[$];

  jk_seq_ctrl #(
    .WIDTH (W),
    .MOD   (M)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .load_val (load_val),
    .q        (q),
    .j_vec    (j_vec),
    .k_vec    (k_vec),
    .tc       (tc),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic int model_nxt(int qv, logic [1:0] m, int lv);
    case (m)
`ifdef JKSC_SAT_EN
      UP:      return (qv == M - 1) ? qv : qv + 1;
      DN:      return (qv == 0) ? qv : qv - 1;
`else
      UP:      return (qv + 1) % M;
      DN:      return (qv + M - 1) % M;
`endif
      LOAD:    return (lv > M - 1) ? M - 1 : lv;
      default: return qv;
    endcase
  endfunction

  // Called at a negedge: drives one command, checks J/K, then checks the edge result.
  task automatic step(input logic [1:0] m, input int lv);
    int           n;
    logic [W-1:0] qo, qn, ej, ek;
    exp_t         e, got;
    mode     = m;
    load_val = W'(lv);
    #1;
    n  = model_nxt(mq, m, lv);
    qo = W'(mq);
    qn = W'(n);
    for (int b = 0; b < W; b++) begin
      ej[b] = (!qo[b] && qn[b]);
      ek[b] = (qo[b] && !qn[b]);
    end
    checks++;
    if (j_vec !== ej || k_vec !== ek) begin
      failures++;
      $display("FAIL jk_drive q=%0d mode=%0d: j=%b k=%b, want j=%b k=%b", mq, m, j_vec, k_vec,
               ej, ek);
    end
    checks++;
    if ((j_vec & k_vec) !== '0) begin
      failures++;
      $display("FAIL jk_legal: j&k=%b, want 0000", j_vec & k_vec);
    end
    e.q    = qn;
    e.tc   = (m == UP && mq == M - 1) || (m == DN && mq == 0);
    e.busy = (m == UP || m == DN);
    sb.push_back(e);
    mq = n;
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: no expected entry");
    end else begin
      e   = sb.pop_front();
      got = '{q: q, tc: tc, busy: busy};
      if (got !== e) begin
        failures++;
        $display("FAIL edge_result: q=%0d tc=%b busy=%b, want q=%0d tc=%b busy=%b", q, tc, busy,
                 e.q, e.tc, e.busy);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode = HOLD;
    load_val = '0;
    @(negedge clk);
    checks++;
    if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_init: q=%0d tc=%b busy=%b, want 0 0 0", q, tc, busy);
    end
    rst = 1'b0;
    mq = 0;
    step(LOAD, 5);
    step(UP, 0);
    step(UP, 0);
    // Assert reset away from any edge while q=7 and busy=1.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (q !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: q=%0d tc=%b busy=%b, want 0 0 0", q, tc, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    mq = 0;
    sb.delete();
    step(UP, 0);
    step(UP, 0);
    step(UP, 0);
    checks++;
    if (q !== 4'd3) begin
      failures++;
      $display("FAIL reset_resume: q=%0d, want 3", q);
    end
  endtask

  task automatic test_up_wrap();
    step(LOAD, 8);
    step(UP, 0);
    step(UP, 0);
    step(UP, 0);
  endtask

  task automatic test_down_wrap();
    step(LOAD, 1);
    step(DN, 0);
    step(DN, 0);
    step(DN, 0);
  endtask

  task automatic test_load_clamp();
    step(LOAD, 13);
    step(LOAD, 4);
    step(HOLD, 0);
    step(LOAD, 15);
    step(LOAD, 10);
    step(HOLD, 0);
  endtask

  task automatic test_saturate();
    step(LOAD, 9);
    step(UP, 0);
    step(UP, 0);
    step(LOAD, 0);
    step(DN, 0);
    step(DN, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      step(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_saturate();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
